// File: rtl/soft_reset_req.sv
// soft_reset_req: initiator of the board reset chain. Turns a long press of
// the (bouncing) BTNC button, or a one-shot game-logic request, into exactly
// one clean active-low reset pulse. After each pulse there is a lockout
// window, and a held button does not auto-repeat.
//
// Ports:
//   pclk          system pixel clock, all logic on its rising edge
//   rst           synchronous active-high reset
//   btn_in        raw asynchronous pushbutton, active-high
//   soft_req      level request from game logic, held until soft_ack
//   soft_ack      one-cycle pulse: soft_req accepted
//   rst_req_n     active-low reset request to the reset chain
//   busy          high while in HOLD, ASSERT or LOCKOUT
//   hold_progress button hold progress 0..255 (0 outside HOLD)
`timescale 1ns/1ps

module soft_reset_req #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 650000,
    parameter int unsigned HOLD_CYCLES     = 65000000,
    parameter int unsigned PULSE_CYCLES    = 16,
    parameter int unsigned LOCKOUT_CYCLES  = 6500000
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       btn_in,
    input  logic       soft_req,
    output logic       soft_ack,
    output logic       rst_req_n,
    output logic       busy,
    output logic [7:0] hold_progress
);

    localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned HOLD_W  = (HOLD_CYCLES > 1)     ? $clog2(HOLD_CYCLES)     : 1;
    localparam int unsigned PULSE_W = (PULSE_CYCLES > 1)    ? $clog2(PULSE_CYCLES)    : 1;
    localparam int unsigned LOCK_W  = (LOCKOUT_CYCLES > 1)  ? $clog2(LOCKOUT_CYCLES)  : 1;

    localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(PULSE_CYCLES - 1);
    localparam logic [LOCK_W-1:0]  LOCK_LAST  = LOCK_W'(LOCKOUT_CYCLES - 1);
    localparam bit                 HOLD_POW2  = ((HOLD_CYCLES & (HOLD_CYCLES - 1)) == 0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_ASSERT  = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser and debounce
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_sync;
    logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
    logic                   db_level_q, db_level_d;

    assign btn_sync = sync_q[SYNC_STAGES-1];

    // Counter runs only while the synchronised input disagrees with the level.
    always_comb begin
        db_cnt_d   = db_cnt_q;
        db_level_d = db_level_q;
        if (btn_sync == db_level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            db_level_d = ~db_level_q;
            db_cnt_d   = '0;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            sync_q     <= '0;
            db_cnt_q   <= '0;
            db_level_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], btn_in};
            db_cnt_q   <= db_cnt_d;
            db_level_q <= db_level_d;
        end
    end

    // ------------------------------------------------------------------
    // Request FSM
    // ------------------------------------------------------------------
    state_t               state_q, state_d;
    logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic [PULSE_W-1:0]   pulse_cnt_q, pulse_cnt_d;
    logic [LOCK_W-1:0]    lock_cnt_q, lock_cnt_d;
    logic                 soft_take;
    logic                 soft_ack_q, soft_ack_d;
    logic                 rst_req_n_q, rst_req_n_d;
    logic                 busy_q, busy_d;
    logic [7:0]           hold_progress_q, hold_progress_d;
    logic [7:0]           scaled_d;

    // State and counter register, plus the output registers.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            hold_cnt_q      <= '0;
            pulse_cnt_q     <= '0;
            lock_cnt_q      <= '0;
            soft_ack_q      <= 1'b0;
            rst_req_n_q     <= 1'b1;
            busy_q          <= 1'b0;
            hold_progress_q <= '0;
        end else begin
            state_q         <= state_d;
            hold_cnt_q      <= hold_cnt_d;
            pulse_cnt_q     <= pulse_cnt_d;
            lock_cnt_q      <= lock_cnt_d;
            soft_ack_q      <= soft_ack_d;
            rst_req_n_q     <= rst_req_n_d;
            busy_q          <= busy_d;
            hold_progress_q <= hold_progress_d;
        end
    end

    // Next state; soft_req outranks the button, counters saturate at their last value.
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        pulse_cnt_d = pulse_cnt_q;
        lock_cnt_d  = lock_cnt_q;
        soft_take   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (soft_req) begin
                    state_d     = ST_ASSERT;
                    pulse_cnt_d = '0;
                    soft_take   = 1'b1;
                end else if (db_level_q) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                end
            end
            ST_HOLD: begin
                if (soft_req) begin
                    state_d     = ST_ASSERT;
                    pulse_cnt_d = '0;
                    soft_take   = 1'b1;
                end else if (!db_level_q) begin
                    state_d = ST_IDLE;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d     = ST_ASSERT;
                    pulse_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            ST_ASSERT: begin
                if (pulse_cnt_q == PULSE_LAST) begin
                    state_d    = ST_LOCKOUT;
                    lock_cnt_d = '0;
                end else begin
                    pulse_cnt_d = pulse_cnt_q + PULSE_W'(1);
                end
            end
            ST_LOCKOUT: begin
                // Held button keeps us here: no auto-repeat.
                if (lock_cnt_q == LOCK_LAST) begin
                    if (!db_level_q) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    lock_cnt_d = lock_cnt_q + LOCK_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Hold progress scaling: plain shift for power-of-two holds, otherwise an
    // incremental floor(count*256/HOLD_CYCLES) tracker that avoids a divider.
    generate
        if (HOLD_POW2) begin : g_shift
            logic [HOLD_W+7:0] prod;
            always_comb begin
                prod     = {hold_cnt_d, 8'd0};
                scaled_d = 8'(prod >> HOLD_W);
            end
        end else begin : g_scaled
            localparam int unsigned     FR_W     = ((HOLD_W > 8) ? HOLD_W : 8) + 1;
            localparam logic [7:0]      STEP_INT = 8'(256 / HOLD_CYCLES);
            localparam logic [FR_W-1:0] STEP_REM = FR_W'(256 % HOLD_CYCLES);
            localparam logic [FR_W-1:0] HOLD_FR  = FR_W'(HOLD_CYCLES);

            logic [7:0]      prog_q, prog_d;
            logic [FR_W-1:0] frac_q, frac_d, frac_sum;

            // Staying in HOLD always means the hold count advanced by one.
            always_comb begin
                frac_sum = frac_q + STEP_REM;
                prog_d   = '0;
                frac_d   = '0;
                if (state_q == ST_HOLD && state_d == ST_HOLD) begin
                    if (frac_sum >= HOLD_FR) begin
                        frac_d = frac_sum - HOLD_FR;
                        prog_d = prog_q + STEP_INT + 8'd1;
                    end else begin
                        frac_d = frac_sum;
                        prog_d = prog_q + STEP_INT;
                    end
                end
            end

            always_ff @(posedge pclk) begin
                if (rst) begin
                    prog_q <= '0;
                    frac_q <= '0;
                end else begin
                    prog_q <= prog_d;
                    frac_q <= frac_d;
                end
            end

            assign scaled_d = prog_d;
        end
    endgenerate

    // Outputs: rst_req_n low the edge after ASSERT is entered, so the pulse
    // length equals the number of cycles spent in ASSERT.
    always_comb begin
        soft_ack_d      = soft_take;
        rst_req_n_d     = (state_q != ST_ASSERT);
        busy_d          = (state_d != ST_IDLE);
        hold_progress_d = 8'd0;
        if (state_d == ST_HOLD) begin
            hold_progress_d = (hold_cnt_d == HOLD_LAST) ? 8'hFF : scaled_d;
        end
    end

    assign soft_ack      = soft_ack_q;
    assign rst_req_n     = rst_req_n_q;
    assign busy          = busy_q;
    assign hold_progress = hold_progress_q;

endmodule

// File: tb/tb_soft_reset_req.sv
`timescale 1ns/1ps

module tb_soft_reset_req;

    localparam int SYNC  = 2;
    localparam int DEB   = 8;
    localparam int HOLD  = 64;
    localparam int PULSE = 4;
    localparam int LOCK  = 32;

    logic       pclk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_in = 1'b0;
    logic       soft_req = 1'b0;
    logic       soft_ack;
    logic       rst_req_n;
    logic       busy;
    logic [7:0] hold_progress;

    always #5 pclk = ~pclk;

    soft_reset_req #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HOLD),
        .PULSE_CYCLES   (PULSE),
        .LOCKOUT_CYCLES (LOCK)
    ) dut (
        .pclk         (pclk),
        .rst          (rst),
        .btn_in       (btn_in),
        .soft_req     (soft_req),
        .soft_ack     (soft_ack),
        .rst_req_n    (rst_req_n),
        .busy         (busy),
        .hold_progress(hold_progress)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: phase + entry timestamp, raw-sample delay line, and
    // the debounced level toggling after DEB consecutive disagreeing samples.
    typedef enum int {M_IDLE, M_HOLD, M_ASSERT, M_LOCK} mphase_t;
    mphase_t m_phase = M_IDLE;
    int      m_edge = 0;
    int      m_entry = 0;
    int      m_last_agree = 0;
    bit      m_db = 1'b0;
    bit      m_q[$];
    bit      e_rst_n = 1'b1;
    bit      e_ack = 1'b0;
    bit      e_busy = 1'b0;
    int      e_prog = 0;

    // Scenario observations
    int low_cnt, ack_cnt, busy_cnt, max_prog, cyc_idx, first_low, last_ack_idx, prog255_idx;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at t=%0t: actual %0d required %0d", name, $time, act, exp);
        end
    endfunction

    // Predict the effect of the next rising edge from the currently driven inputs.
    task automatic model_edge();
        mphase_t pre;
        bit      seen;
        bit      took;
        int      k;
        m_edge++;
        pre  = m_phase;
        took = 1'b0;
        if (rst) begin
            m_q.delete();
            for (int i = 0; i < SYNC; i++) m_q.push_back(1'b0);
            m_db         = 1'b0;
            m_last_agree = m_edge;
            m_phase      = M_IDLE;
            e_rst_n      = 1'b1;
            e_ack        = 1'b0;
            e_busy       = 1'b0;
            e_prog       = 0;
        end else begin
            seen = m_q.pop_front();
            m_q.push_back(btn_in);
            case (m_phase)
                M_IDLE: begin
                    if (soft_req) begin
                        m_phase = M_ASSERT; m_entry = m_edge; took = 1'b1;
                    end else if (m_db) begin
                        m_phase = M_HOLD; m_entry = m_edge;
                    end
                end
                M_HOLD: begin
                    if (soft_req) begin
                        m_phase = M_ASSERT; m_entry = m_edge; took = 1'b1;
                    end else if (!m_db) begin
                        m_phase = M_IDLE;
                    end else if (m_edge - m_entry == HOLD) begin
                        m_phase = M_ASSERT; m_entry = m_edge;
                    end
                end
                M_ASSERT: begin
                    if (m_edge - m_entry == PULSE) begin
                        m_phase = M_LOCK; m_entry = m_edge;
                    end
                end
                default: begin
                    if (m_edge - m_entry >= LOCK && !m_db) m_phase = M_IDLE;
                end
            endcase
            if (seen == m_db) begin
                m_last_agree = m_edge;
            end else if (m_edge - m_last_agree == DEB) begin
                m_db         = !m_db;
                m_last_agree = m_edge;
            end
            e_rst_n = (pre != M_ASSERT);
            e_ack   = took;
            e_busy  = (m_phase != M_IDLE);
            if (m_phase == M_HOLD) begin
                k      = m_edge - m_entry;
                e_prog = (k == HOLD - 1) ? 255 : (k * 256) / HOLD;
            end else begin
                e_prog = 0;
            end
        end
    endtask

    task automatic clear_obs();
        low_cnt = 0; ack_cnt = 0; busy_cnt = 0; max_prog = 0;
        cyc_idx = 0; first_low = -1; last_ack_idx = -1; prog255_idx = -1;
    endtask

    // One clock: drive at negedge, model the edge, compare at the next negedge.
    task automatic cyc(input bit r, input bit b, input bit s);
        rst      = r;
        btn_in   = b;
        soft_req = s;
        model_edge();
        @(negedge pclk);
        chk("rst_req_n", int'(rst_req_n), int'(e_rst_n));
        chk("soft_ack", int'(soft_ack), int'(e_ack));
        chk("busy", int'(busy), int'(e_busy));
        chk("hold_progress", int'(hold_progress), e_prog);
        if (!rst_req_n) begin
            low_cnt++;
            if (first_low < 0) first_low = cyc_idx;
        end
        if (soft_ack) begin
            ack_cnt++;
            last_ack_idx = cyc_idx;
        end
        if (busy) busy_cnt++;
        if (int'(hold_progress) > max_prog) max_prog = int'(hold_progress);
        if (hold_progress == 8'hFF && prog255_idx < 0) prog255_idx = cyc_idx;
        cyc_idx++;
    endtask

    typedef struct {
        bit         r;
        bit         b;
        bit         s;
        bit         x_rst_n;
        bit         x_ack;
        bit         x_busy;
        logic [7:0] x_prog;
    } vec_t;

    initial begin
        vec_t tbl[9];
        bit   rb, sb, rr;
        int   btn_left;
        bit   found;

        for (int i = 0; i < SYNC; i++) m_q.push_back(1'b0);

        // Reset, then a soft request walked through ASSERT into LOCKOUT.
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0};

        @(negedge pclk);
        clear_obs();
        for (int i = 0; i < 9; i++) begin
            cyc(tbl[i].r, tbl[i].b, tbl[i].s);
            chk("tbl_rst_req_n", int'(rst_req_n), int'(tbl[i].x_rst_n));
            chk("tbl_soft_ack", int'(soft_ack), int'(tbl[i].x_ack));
            chk("tbl_busy", int'(busy), int'(tbl[i].x_busy));
            chk("tbl_hold_progress", int'(hold_progress), int'(tbl[i].x_prog));
        end
        repeat (40) cyc(1'b0, 1'b0, 1'b0);
        chk("lockout_exit_busy", int'(busy), 0);

        // Reset during ASSERT releases rst_req_n on the next edge.
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("assert_low_before_rst", int'(rst_req_n), 0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("rst_mid_pulse", int'(rst_req_n), 1);
        chk("rst_mid_pulse_busy", int'(busy), 0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0);

        // Bounce rejection: toggle every 3 cycles.
        clear_obs();
        for (int i = 0; i < 100; i++) cyc(1'b0, 1'((i / 3) % 2), 1'b0);
        repeat (20) cyc(1'b0, 1'b0, 1'b0);
        chk("bounce_busy_cycles", busy_cnt, 0);
        chk("bounce_low_cycles", low_cnt, 0);

        // Short press: HOLD visited, no pulse.
        clear_obs();
        repeat (40) cyc(1'b0, 1'b1, 1'b0);
        repeat (60) cyc(1'b0, 1'b0, 1'b0);
        chk("short_hold_seen", int'(busy_cnt > 0), 1);
        chk("short_prog_seen", int'(max_prog > 0), 1);
        chk("short_low_cycles", low_cnt, 0);
        chk("short_end_prog", int'(hold_progress), 0);
        chk("short_end_busy", int'(busy), 0);

        // Long press: one 4-cycle pulse at SYNC+DEB+HOLD+1, held button stays locked out.
        clear_obs();
        repeat (200) cyc(1'b0, 1'b1, 1'b0);
        chk("long_first_low", first_low, SYNC + DEB + HOLD + 1);
        chk("long_low_cycles", low_cnt, PULSE);
        chk("long_prog_max", max_prog, 255);
        chk("long_prog255_idx", prog255_idx, SYNC + DEB + HOLD - 1);
        chk("long_held_busy", int'(busy), 1);
        repeat (80) cyc(1'b0, 1'b0, 1'b0);
        chk("long_release_busy", int'(busy), 0);
        chk("long_single_pulse", low_cnt, PULSE);

        // Soft request held through LOCKOUT: second ack only once IDLE returns.
        clear_obs();
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            cyc(1'b0, 1'b0, 1'b1);
            if (ack_cnt >= 2) found = 1'b1;
        end
        if (!found) chk("soft_second_ack_timeout", 0, 1);
        chk("soft_second_ack_idx", last_ack_idx, PULSE + LOCK + 1);
        repeat (60) cyc(1'b0, 1'b0, 1'b0);
        chk("soft_ack_count", ack_cnt, 2);
        chk("soft_low_cycles", low_cnt, 2 * PULSE);

        // Soft request on the very edge the hold expires: exactly one pulse.
        clear_obs();
        found = 1'b0;
        for (int i = 0; i < 150 && !found; i++) begin
            cyc(1'b0, 1'b1, 1'b0);
            if (hold_progress == 8'hFF) found = 1'b1;
        end
        if (!found) chk("simul_hold_timeout", 0, 1);
        cyc(1'b0, 1'b1, 1'b1);
        chk("simul_ack", int'(soft_ack), 1);
        repeat (10) cyc(1'b0, 1'b1, 1'b0);
        repeat (80) cyc(1'b0, 1'b0, 1'b0);
        chk("simul_ack_count", ack_cnt, 1);
        chk("simul_low_cycles", low_cnt, PULSE);
        chk("simul_end_busy", int'(busy), 0);

        // Random traffic against the model.
        btn_left = 0;
        rb = 1'b0;
        sb = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (btn_left == 0) begin
                rb       = 1'($urandom_range(1, 0));
                btn_left = int'($urandom_range(120, 1));
            end
            btn_left--;
            if (!sb && $urandom_range(199, 0) == 0) sb = 1'b1;
            rr = ($urandom_range(599, 0) == 0);
            cyc(rr, rb, sb);
            if (e_ack) sb = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, actual running required finished");
        $fatal(1);
    end

endmodule
